fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_if.sv | 25 ++
 rtl/fetch_sequencer.sv | 148 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, its combinational instruction memory,
// the redirect source and the instruction consumer.
interface fetch_sequencer_if;
    logic        start;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        busy;
    logic        halted;

    modport master (
        input  start, imem_data, redirect_valid, redirect_pc, instr_ready,
        output imem_addr, instr_valid, instr, instr_pc, busy, halted
    );

    modport slave (
        output start, imem_data, redirect_valid, redirect_pc, instr_ready,
        input  imem_addr, instr_valid, instr, instr_pc, busy, halted
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE/RUN/HALT control, 2-entry {instr, pc} buffer, redirect flush.
// Optional feature macro: FETCH_HALT_DETECT_EN enables halt-word detection and the HALT state.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] HALT_WORD = 16'hF000
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

`ifdef FETCH_HALT_DETECT_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] fetch_pc_r;
    logic [15:0] fetch_pc_nxt_s;
    logic [15:0] instr_mem_r [2];
    logic [15:0] pc_mem_r    [2];
    logic        rd_ptr_r;
    logic        wr_ptr_r;
    logic [1:0]  count_r;
    logic        redirect_s;
    logic        pop_s;
    logic        fetch_s;
    logic        halt_hit_s;

    // Event decode; a redirect outside IDLE masks every other action this cycle.
    always_comb begin
        redirect_s = bus.redirect_valid && (state_r != IDLE);
        pop_s      = !redirect_s && (count_r != 2'd0) && bus.instr_ready;
        fetch_s    = !redirect_s && (state_r == RUN) && ((count_r != 2'd2) || pop_s);
        halt_hit_s = HALT_EN && fetch_s && (bus.imem_data == HALT_WORD);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (redirect_s) begin
                    state_nxt_s = RUN;
                end else if (halt_hit_s) begin
                    state_nxt_s = HALT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            HALT: begin
                if (redirect_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = HALT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode; all outputs come straight from registers.
    always_comb begin
        bus.imem_addr   = fetch_pc_r;
        bus.busy        = (state_r != IDLE);
        bus.halted      = HALT_EN && (state_r == HALT);
        bus.instr_valid = (count_r != 2'd0);
        if (count_r != 2'd0) begin
            bus.instr    = instr_mem_r[rd_ptr_r];
            bus.instr_pc = pc_mem_r[rd_ptr_r];
        end else begin
            bus.instr    = 16'h0000;
            bus.instr_pc = 16'h0000;
        end
    end

    // Fetch address update; a halt word freezes the address on the halt location.
    always_comb begin
        if (redirect_s) begin
            fetch_pc_nxt_s = bus.redirect_pc;
        end else if (fetch_s && !halt_hit_s) begin
            fetch_pc_nxt_s = fetch_pc_r + 16'd1;
        end else begin
            fetch_pc_nxt_s = fetch_pc_r;
        end
    end

    // Fetch address register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r <= RESET_PC;
        end else begin
            fetch_pc_r <= fetch_pc_nxt_s;
        end
    end

    // Two-entry instruction buffer with flush on redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                instr_mem_r[i] <= 16'h0000;
                pc_mem_r[i]    <= 16'h0000;
            end
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (redirect_s) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (fetch_s) begin
                instr_mem_r[wr_ptr_r] <= bus.imem_data;
                pc_mem_r[wr_ptr_r]    <= fetch_pc_r;
                wr_ptr_r              <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, fetch_s} - {1'b0, pop_s};
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: table-driven main stream plus stall, reset and halt sequences.
module tb_fetch_sequencer;

    logic clk;
    logic rst_n;
    logic halt_mode;
    int   checks;
    int   errors;

    fetch_sequencer_if bus ();

    fetch_sequencer #(
        .RESET_PC (16'h0000),
        .HALT_WORD(16'hF000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic        start;
        logic        redir;
        logic [15:0] rpc;
        logic        ready;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [15:0] e_pc;
        logic        e_busy;
        logic [15:0] e_addr;
    } vec_t;

    vec_t tbl [16];

    // Memory image: word(a) = C000 ^ a, optionally with a halt word at address 2.
    function automatic logic [15:0] mem_word(input logic [15:0] a, input logic hm);
        if (hm && (a == 16'd2)) begin
            return 16'hF000;
        end
        return 16'hC000 ^ a;
    endfunction

    always_comb bus.imem_data = mem_word(bus.imem_addr, halt_mode);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [15:0] ins,
                           input logic [15:0] pc, input logic b, input logic h,
                           input logic [15:0] addr);
        chk({tag, ".instr_valid"}, {15'd0, bus.instr_valid}, {15'd0, v});
        chk({tag, ".instr"},       bus.instr, ins);
        chk({tag, ".instr_pc"},    bus.instr_pc, pc);
        chk({tag, ".busy"},        {15'd0, bus.busy}, {15'd0, b});
        chk({tag, ".halted"},      {15'd0, bus.halted}, {15'd0, h});
        chk({tag, ".imem_addr"},   bus.imem_addr, addr);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        checks             = 0;
        errors             = 0;
        halt_mode          = 1'b0;
        rst_n              = 1'b0;
        bus.start          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;
        bus.instr_ready    = 1'b0;

        //          start redir rpc      rdy  valid instr     pc        busy addr
        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000};
        tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hC000, 16'h0000, 1'b1, 16'h0001};
        tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hC001, 16'h0001, 1'b1, 16'h0002};
        tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hC002, 16'h0002, 1'b1, 16'h0003};
        tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hC003, 16'h0003, 1'b1, 16'h0004};
        tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hC003, 16'h0003, 1'b1, 16'h0005};
        tbl[7]  = '{1'b0, 1'b1, 16'h0009, 1'b0, 1'b1, 16'hC003, 16'h0003, 1'b1, 16'h0005};
        tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0009};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hC009, 16'h0009, 1'b1, 16'h000A};
        tbl[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hC00A, 16'h000A, 1'b1, 16'h000B};
        tbl[11] = '{1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 16'hC00B, 16'h000B, 1'b1, 16'h000C};
        tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFF};
        tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h3FFF, 16'hFFFF, 1'b1, 16'h0000};
        tbl[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h3FFF, 16'hFFFF, 1'b1, 16'h0001};
        tbl[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hC000, 16'h0000, 1'b1, 16'h0002};

        // Reset state while rst_n is held low.
        repeat (2) @(negedge clk);
        #1;
        chk_out("reset", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Main stream: delivery, stall, redirect while full, start ignored, address wrap.
        for (int i = 0; i < 16; i++) begin
            bus.start          = tbl[i].start;
            bus.redirect_valid = tbl[i].redir;
            bus.redirect_pc    = tbl[i].rpc;
            bus.instr_ready    = tbl[i].ready;
            #1;
            chk_out($sformatf("row%0d", i), tbl[i].e_valid, tbl[i].e_instr, tbl[i].e_pc,
                    tbl[i].e_busy, 1'b0, tbl[i].e_addr);
            @(negedge clk);
        end
        bus.start          = 1'b0;
        bus.redirect_valid = 1'b0;

        // Consumer stall right after start: buffer fills to two and fetching stops.
        pulse_reset();
        bus.start       = 1'b1;
        bus.instr_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk_out("stall", 1'b1, 16'hC000, 16'h0000, 1'b1, 1'b0, 16'h0002);
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d.instr", k), bus.instr, 16'hC000 ^ 16'(k));
            chk($sformatf("drain%0d.pc", k), bus.instr_pc, 16'(k));
            @(negedge clk);
            #1;
        end

        // Asynchronous reset with a full buffer, checked before any clock edge.
        bus.instr_ready = 1'b0;
        @(negedge clk);
        #2;
        chk("prereset.valid", {15'd0, bus.instr_valid}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
        #1;
        rst_n = 1'b1;
        @(negedge clk);

        // Halt word at address 2.
        halt_mode       = 1'b1;
        bus.start       = 1'b1;
        bus.instr_ready = 1'b1;
        #1;
        chk_out("h0", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        chk_out("h1", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        #1;
        chk_out("h2", 1'b1, 16'hC000, 16'h0000, 1'b1, 1'b0, 16'h0001);
        @(negedge clk);
        #1;
        chk_out("h3", 1'b1, 16'hC001, 16'h0001, 1'b1, 1'b0, 16'h0002);
        @(negedge clk);
        #1;
`ifdef FETCH_HALT_DETECT_EN
        chk_out("h4", 1'b1, 16'hF000, 16'h0002, 1'b1, 1'b1, 16'h0002);
        @(negedge clk);
        #1;
        chk_out("h5", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0002);
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0000;
        #1;
        chk_out("h6", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0002);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        chk_out("h7", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        #1;
        chk_out("h8", 1'b1, 16'hC000, 16'h0000, 1'b1, 1'b0, 16'h0001);
`else
        chk_out("h4", 1'b1, 16'hF000, 16'h0002, 1'b1, 1'b0, 16'h0003);
        @(negedge clk);
        #1;
        chk_out("h5", 1'b1, 16'hC003, 16'h0003, 1'b1, 1'b0, 16'h0004);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
